// File: rtl/xdma_pkg.sv
// xdma_pkg: shared XDMA message types and the finish sender state encoding
package xdma_pkg;
  typedef struct packed {
    logic [7:0]  flags;
    logic [15:0] dma_id;
  } xdma_to_remote_finish_t;
  typedef enum logic [1:0] {Idle, Send, WaitRsp, Retry} xdma_finish_sender_state_t;
endpackage

// File: rtl/xdma_finish_fifo.sv
// xdma_finish_fifo: registered-output FIFO of pending finish entries, no fall-through
module xdma_finish_fifo #(
  parameter type entry_t = logic,
  parameter int Depth = 4,
  parameter int CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  entry_t              entry_i,
  input  logic                pop_i,
  output entry_t              entry_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] cnt_o
);
  localparam int PtrW = $clog2(Depth);
  entry_t mem [Depth];
  logic [PtrW-1:0] wptr, rptr;
  logic [CntWidth-1:0] cnt;
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wptr] <= entry_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      wptr <= push_i ? wptr + PtrW'(1) : wptr;
      rptr <= pop_i ? rptr + PtrW'(1) : rptr;
      cnt  <= cnt + CntWidth'(push_i) - CntWidth'(pop_i);
    end
  end
  assign entry_o = mem[rptr];
  assign full_o  = cnt == CntWidth'(Depth);
  assign empty_o = cnt == '0;
  assign cnt_o   = cnt;
endmodule

// File: rtl/xdma_finish_sender.sv
// xdma_finish_sender: queues finish requests and sends them one at a time to the previous hop (resend on error with XDMA_FINISH_SENDER_RETRY_EN)
module xdma_finish_sender #(
  parameter type id_t = logic [15:0],
  parameter type addr_t = logic [31:0],
  parameter type data_t = logic [63:0],
  parameter type xdma_to_remote_finish_t = xdma_pkg::xdma_to_remote_finish_t,
  parameter int FifoDepth = 4,
  parameter int CntWidth = $clog2(FifoDepth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                finish_req_valid_i,
  output logic                finish_req_ready_o,
  input  addr_t               finish_req_addr_i,
  input  id_t                 finish_req_dma_id_i,
  output logic                finish_valid_o,
  input  logic                finish_ready_i,
  output addr_t               finish_addr_o,
  output data_t               finish_data_o,
  input  logic                finish_rsp_valid_i,
  input  logic                finish_rsp_err_i,
  output logic                finish_rsp_ready_o,
  output logic [CntWidth-1:0] pending_cnt_o,
  output logic                busy_o,
  output logic                err_o
);
  import xdma_pkg::*;
  typedef struct packed {
    addr_t addr;
    id_t   dma_id;
  } entry_t;
  entry_t head;
  logic full, empty, push, pop;
  logic [CntWidth-1:0] cnt;
  xdma_finish_sender_state_t state_q, state_d;
  xdma_to_remote_finish_t msg;
  assign finish_req_ready_o = ~full & ~rst_i;
  assign push = finish_req_valid_i & finish_req_ready_o;
  xdma_finish_fifo #(.entry_t(entry_t), .Depth(FifoDepth), .CntWidth(CntWidth)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .entry_i ({finish_req_addr_i, finish_req_dma_id_i}),
    .pop_i   (pop),
    .entry_o (head),
    .full_o  (full),
    .empty_o (empty),
    .cnt_o   (cnt)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= Idle;
    else state_q <= state_d;
  end
`ifdef XDMA_FINISH_SENDER_RETRY_EN
  logic [1:0] retry_q, retry_d;
  always_ff @(posedge clk_i) begin
    if (rst_i) retry_q <= '0;
    else retry_q <= retry_d;
  end
`endif
  always_comb begin
    msg = '0;
    msg.dma_id = head.dma_id;
    state_d = state_q;
    finish_valid_o = 1'b0;
    finish_rsp_ready_o = 1'b0;
    pop = 1'b0;
    err_o = 1'b0;
`ifdef XDMA_FINISH_SENDER_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      Idle: state_d = empty ? Idle : Send;
      Send: begin
        finish_valid_o = 1'b1;
        state_d = finish_ready_i ? WaitRsp : Send;
      end
      WaitRsp: begin
        finish_rsp_ready_o = 1'b1;
        if (finish_rsp_valid_i) begin
`ifdef XDMA_FINISH_SENDER_RETRY_EN
          if (finish_rsp_err_i && retry_q != 2'd3) begin
            state_d = Retry;
            retry_d = retry_q + 2'd1;
          end else begin
            pop = 1'b1;
            err_o = finish_rsp_err_i;
            retry_d = '0;
            state_d = cnt > CntWidth'(1) ? Send : Idle;
          end
`else
          pop = 1'b1;
          err_o = finish_rsp_err_i;
          state_d = cnt > CntWidth'(1) ? Send : Idle;
`endif
        end
      end
      default: state_d = Send;
    endcase
    // address/data are only driven while a write is offered so idle outputs read as 0
    finish_addr_o = finish_valid_o ? head.addr : '0;
    finish_data_o = '0;
    if (finish_valid_o) finish_data_o[$bits(xdma_to_remote_finish_t)-1:0] = msg;
  end
  assign pending_cnt_o = cnt;
  assign busy_o = (state_q != Idle) | ~empty;
endmodule

// File: tb/tb_xdma_finish_sender.sv
// tb_xdma_finish_sender: directed stimulus checked every cycle against a queue-level model of the finish sender
module tb_xdma_finish_sender;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic finish_req_valid_i = 1'b0, finish_ready_i = 1'b0;
  logic finish_rsp_valid_i = 1'b0, finish_rsp_err_i = 1'b0;
  logic [31:0] finish_req_addr_i = '0;
  logic [15:0] finish_req_dma_id_i = '0;
  logic finish_req_ready_o, finish_valid_o, finish_rsp_ready_o, busy_o, err_o;
  logic [31:0] finish_addr_o;
  logic [63:0] finish_data_o;
  logic [2:0] pending_cnt_o;

  xdma_finish_sender dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .finish_req_valid_i(finish_req_valid_i), .finish_req_ready_o(finish_req_ready_o),
    .finish_req_addr_i(finish_req_addr_i), .finish_req_dma_id_i(finish_req_dma_id_i),
    .finish_valid_o(finish_valid_o), .finish_ready_i(finish_ready_i),
    .finish_addr_o(finish_addr_o), .finish_data_o(finish_data_o),
    .finish_rsp_valid_i(finish_rsp_valid_i), .finish_rsp_err_i(finish_rsp_err_i),
    .finish_rsp_ready_o(finish_rsp_ready_o), .pending_cnt_o(pending_cnt_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [15:0] id;
  } ent_t;
  ent_t q[$];
  logic [15:0] issued[$];
  bit outstanding = 0;
  int cyc = 0, earliest = 0, errcnt = 0, sends = 0, errpulses = 0;

  initial begin
    bit rdy_exp, vld_exp, fin, snd, rsp;
    @(posedge clk_i);
    forever begin
      @(negedge clk_i);
      cyc++;
      rdy_exp = !rst_i && q.size() < 4;
      vld_exp = q.size() != 0 && !outstanding && cyc >= earliest;
      chk("req_ready", finish_req_ready_o, rdy_exp);
      chk("pending_cnt", pending_cnt_o, q.size());
      chk("busy", busy_o, q.size() != 0);
      chk("rsp_ready", finish_rsp_ready_o, outstanding);
      chk("valid", finish_valid_o, vld_exp);
      chk("addr", finish_addr_o, vld_exp ? q[0].addr : 32'h0);
      chk("data", finish_data_o, vld_exp ? 64'(q[0].id) : 64'h0);
`ifdef XDMA_FINISH_SENDER_RETRY_EN
      fin = errcnt == 3;
`else
      fin = 1;
`endif
      if (!rst_i) chk("err", err_o, outstanding && finish_rsp_valid_i && finish_rsp_err_i && fin);
      if (err_o) errpulses++;
      if (rst_i) begin
        q.delete();
        outstanding = 0;
        errcnt = 0;
      end else begin
        snd = vld_exp && finish_ready_i;
        rsp = outstanding && finish_rsp_valid_i;
        if (snd) begin
          outstanding = 1;
          sends++;
          issued.push_back(q[0].id);
        end
        if (rsp) begin
          outstanding = 0;
          if (finish_rsp_err_i && !fin) begin
            errcnt++;
            earliest = cyc + 2;
          end else begin
            void'(q.pop_front());
            errcnt = 0;
            if (q.size() != 0) earliest = cyc + 1;
          end
        end
        if (finish_req_valid_i && rdy_exp) begin
          if (q.size() == 0) earliest = cyc + 2;
          q.push_back('{finish_req_addr_i, finish_req_dma_id_i});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [15:0] id);
    finish_req_valid_i = 1'b1;
    finish_req_addr_i = a;
    finish_req_dma_id_i = id;
    for (int i = 0; i < 60 && !finish_req_ready_o; i++) tick();
    chk("push_timeout", finish_req_ready_o, 1);
    tick();
    finish_req_valid_i = 1'b0;
  endtask

  task automatic respond(input logic e);
    for (int i = 0; i < 60 && !finish_rsp_ready_o; i++) tick();
    chk("rsp_timeout", finish_rsp_ready_o, 1);
    finish_rsp_valid_i = 1'b1;
    finish_rsp_err_i = e;
    tick();
    finish_rsp_valid_i = 1'b0;
    finish_rsp_err_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, e0;
    repeat (3) tick();
    chk("rst_ready", finish_req_ready_o, 0);
    chk("rst_valid", finish_valid_o, 0);
    chk("rst_cnt", pending_cnt_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_i = 1'b0;
    // single request: valid two cycles after acceptance
    finish_req_valid_i = 1'b1;
    finish_req_addr_i = 32'h1000_0040;
    finish_req_dma_id_i = 16'd5;
    tick();
    finish_req_valid_i = 1'b0;
    chk("t1_n1_valid", finish_valid_o, 0);
    chk("t1_n1_cnt", pending_cnt_o, 1);
    tick();
    chk("t1_n2_valid", finish_valid_o, 1);
    chk("t1_addr", finish_addr_o, 32'h1000_0040);
    chk("t1_data", finish_data_o, 64'd5);
    finish_ready_i = 1'b1;
    tick();
    finish_ready_i = 1'b0;
    tick();
    tick();
    finish_rsp_valid_i = 1'b1;
    chk("t1_cnt_before", pending_cnt_o, 1);
    tick();
    finish_rsp_valid_i = 1'b0;
    chk("t1_cnt_after", pending_cnt_o, 0);
    chk("t1_busy_after", busy_o, 0);
    // fill the FIFO, fifth request waits for the first response
    issued.delete();
    for (int i = 1; i <= 4; i++) push(32'h2000_0000 + 32'(i * 16), 16'(i));
    chk("t2_full_ready", finish_req_ready_o, 0);
    chk("t2_full_cnt", pending_cnt_o, 4);
    repeat (3) tick();
    finish_ready_i = 1'b1;
    fork
      push(32'h2000_0050, 16'd5);
      repeat (5) respond(1'b0);
    join
    chk("t2_issued_n", issued.size(), 5);
    for (int i = 0; i < 5 && i < issued.size(); i++) chk("t2_order", issued[i], 16'(i + 1));
    // response while the write is still unaccepted must be ignored
    finish_ready_i = 1'b0;
    push(32'h3000_0000, 16'h33);
    for (int i = 0; i < 20 && !finish_valid_o; i++) tick();
    chk("t3_valid", finish_valid_o, 1);
    finish_rsp_valid_i = 1'b1;
    repeat (5) begin
      chk("t3_rsp_ready", finish_rsp_ready_o, 0);
      chk("t3_addr", finish_addr_o, 32'h3000_0000);
      chk("t3_data", finish_data_o, 64'h33);
      tick();
    end
    finish_rsp_valid_i = 1'b0;
    chk("t3_cnt", pending_cnt_o, 1);
    finish_ready_i = 1'b1;
    respond(1'b0);
    // error responses
    e0 = errpulses;
`ifdef XDMA_FINISH_SENDER_RETRY_EN
    s0 = sends;
    push(32'h4000_0000, 16'd9);
    respond(1'b1);
    respond(1'b1);
    respond(1'b0);
    chk("t5_sends", sends - s0, 3);
    chk("t5_no_err", errpulses - e0, 0);
    chk("t5_cnt", pending_cnt_o, 0);
    s0 = sends;
    push(32'h4000_0010, 16'd10);
    repeat (4) respond(1'b1);
    chk("t5_sends4", sends - s0, 4);
    chk("t5_err", errpulses - e0, 1);
    chk("t5_cnt4", pending_cnt_o, 0);
`else
    s0 = sends;
    finish_ready_i = 1'b0;
    push(32'h4000_0000, 16'd7);
    push(32'h4000_0010, 16'd8);
    finish_ready_i = 1'b1;
    respond(1'b1);
    chk("t4_err", errpulses - e0, 1);
    chk("t4_next_valid", finish_valid_o, 1);
    chk("t4_next_addr", finish_addr_o, 32'h4000_0010);
    chk("t4_cnt", pending_cnt_o, 1);
    respond(1'b0);
    chk("t4_sends", sends - s0, 2);
`endif
    // reset while waiting for a response with three entries queued
    finish_ready_i = 1'b0;
    push(32'h5000_0000, 16'd21);
    push(32'h5000_0010, 16'd22);
    push(32'h5000_0020, 16'd23);
    finish_ready_i = 1'b1;
    for (int i = 0; i < 20 && !finish_rsp_ready_o; i++) tick();
    chk("t6_waitrsp", finish_rsp_ready_o, 1);
    chk("t6_cnt3", pending_cnt_o, 3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t6_cnt", pending_cnt_o, 0);
    chk("t6_valid", finish_valid_o, 0);
    chk("t6_rsp_ready", finish_rsp_ready_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_err", err_o, 0);
    chk("t6_addr", finish_addr_o, 0);
    finish_rsp_valid_i = 1'b1;
    finish_rsp_err_i = 1'b1;
    repeat (2) tick();
    finish_rsp_valid_i = 1'b0;
    finish_rsp_err_i = 1'b0;
    chk("t6_late_cnt", pending_cnt_o, 0);
    chk("t6_late_busy", busy_o, 0);
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
